// File: rtl/calc_pkg.sv
// Shared types and helpers for the sequential calculator core.
// The op and state encodings are common to the whole slice.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DIV0 = 2'd3
  } state_t;

  localparam int NUM_OPS = 4;

  // Number of set bits; anything other than 1 means no single op was pressed.
  function automatic logic [2:0] onehot_count(input logic [NUM_OPS-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_OPS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Per-bit synchroniser followed by a history flop.
// Produces a one-cycle pulse on each synchronised rising edge.
module btn_edge_sync #(
  parameter int N           = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] pulse
);

  logic [N-1:0] sync_r [SYNC_STAGES];
  logic [N-1:0] hist_r;

  // Synchroniser chain plus history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {N{1'b0}};
      end
      hist_r <= {N{1'b0}};
    end else begin
      sync_r[0] <= btn_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/calc_seq_core.sv
// Sequential calculator: single-cycle ADD/SUB, WIDTH-cycle shift-add MUL and
// restoring DIV sharing one accumulator/shift-register pair.
module calc_seq_core
  import calc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               BTN_ADD,
  input  logic               BTN_SUB,
  input  logic               BTN_MUL,
  input  logic               BTN_DIV,
  input  logic               BTNC,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic               done,
  output logic               err_div0
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [4:0]         pulse_s;
  logic               clr_s;
  logic [3:0]         op_btn_s;
  logic               accept_s;
  op_t                op_s;
  state_t             state_r, state_nx_s;

  logic [WIDTH-1:0]   acc_r, acc_nx_s;
  logic [WIDTH-1:0]   shreg_r, shreg_nx_s;
  logic [WIDTH-1:0]   b_r, b_nx_s;
  logic [CW-1:0]      cnt_r, cnt_nx_s;
  logic [2*WIDTH-1:0] out_r, out_nx_s;
  logic               busy_r, busy_nx_s;
  logic               done_r, done_nx_s;
  logic               err_r, err_nx_s;

  logic [WIDTH:0]     add_s;
  logic [2*WIDTH-1:0] sub_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_trial_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic               div_ge_s;

  btn_edge_sync #(
    .N          (5),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_sync (
    .clk    (CLK100MHZ),
    .rst_n  (CPU_RESETN),
    .btn_raw({BTNC, BTN_DIV, BTN_MUL, BTN_SUB, BTN_ADD}),
    .pulse  (pulse_s)
  );

  assign clr_s    = pulse_s[4];
  assign op_btn_s = pulse_s[3:0];
  assign accept_s = (state_r == S_IDLE) && !clr_s && (onehot_count(op_btn_s) == 3'd1);

  // Map the single pressed op button onto the op encoding
  always_comb begin
    case (op_btn_s)
      4'b0001: op_s = OP_ADD;
      4'b0010: op_s = OP_SUB;
      4'b0100: op_s = OP_MUL;
      4'b1000: op_s = OP_DIV;
      default: op_s = OP_ADD;
    endcase
  end

  assign add_s       = {1'b0, A} + {1'b0, B};
  assign sub_s       = {{WIDTH{1'b0}}, A} - {{WIDTH{1'b0}}, B};
  assign mul_sum_s   = {1'b0, acc_r} + (shreg_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
  assign div_trial_s = {acc_r, shreg_r[WIDTH-1]};
  assign div_ge_s    = div_trial_s >= {1'b0, b_r};
  // A partial remainder below b_r always fits in WIDTH bits, so modulo subtraction suffices
  assign div_diff_s  = div_trial_s[WIDTH-1:0] - b_r;

  // FSM state register
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; clear wins over everything
  always_comb begin
    state_nx_s = state_r;
    if (clr_s) begin
      state_nx_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            case (op_s)
              OP_MUL:  state_nx_s = S_MUL;
              OP_DIV:  state_nx_s = (B == {WIDTH{1'b0}}) ? S_DIV0 : S_DIV;
              default: state_nx_s = S_IDLE;
            endcase
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_r == CNT_LAST) begin
            state_nx_s = S_IDLE;
          end else begin
            state_nx_s = state_r;
          end
        end
        S_DIV0:  state_nx_s = S_IDLE;
        default: state_nx_s = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    acc_nx_s   = acc_r;
    shreg_nx_s = shreg_r;
    b_nx_s     = b_r;
    cnt_nx_s   = cnt_r;
    out_nx_s   = out_r;
    busy_nx_s  = busy_r;
    done_nx_s  = 1'b0;
    err_nx_s   = err_r;
    if (clr_s) begin
      out_nx_s  = {(2*WIDTH){1'b0}};
      err_nx_s  = 1'b0;
      busy_nx_s = 1'b0;
      cnt_nx_s  = {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            err_nx_s   = 1'b0;
            b_nx_s     = B;
            shreg_nx_s = A;
            acc_nx_s   = {WIDTH{1'b0}};
            cnt_nx_s   = {CW{1'b0}};
            case (op_s)
              OP_ADD: begin
                out_nx_s  = {{(WIDTH-1){1'b0}}, add_s};
                done_nx_s = 1'b1;
              end
              OP_SUB: begin
                out_nx_s  = sub_s;
                done_nx_s = 1'b1;
              end
              default: begin
                out_nx_s = out_r;
              end
            endcase
          end else begin
            done_nx_s = 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_r == CNT_LAST) begin
            out_nx_s  = {acc_r, shreg_r};
            done_nx_s = 1'b1;
            busy_nx_s = 1'b0;
          end else begin
            busy_nx_s = 1'b1;
            cnt_nx_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (state_r == S_MUL) begin
              acc_nx_s   = mul_sum_s[WIDTH:1];
              shreg_nx_s = {mul_sum_s[0], shreg_r[WIDTH-1:1]};
            end else begin
              acc_nx_s   = div_ge_s ? div_diff_s : div_trial_s[WIDTH-1:0];
              shreg_nx_s = {shreg_r[WIDTH-2:0], div_ge_s};
            end
          end
        end
        S_DIV0: begin
          out_nx_s  = {shreg_r, {WIDTH{1'b1}}};
          err_nx_s  = 1'b1;
          done_nx_s = 1'b1;
        end
        default: begin
          busy_nx_s = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      acc_r   <= {WIDTH{1'b0}};
      shreg_r <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      out_r   <= {(2*WIDTH){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      acc_r   <= acc_nx_s;
      shreg_r <= shreg_nx_s;
      b_r     <= b_nx_s;
      cnt_r   <= cnt_nx_s;
      out_r   <= out_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
      err_r   <= err_nx_s;
    end
  end

  assign out      = out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err_div0 = err_r;

endmodule

// File: tb/tb_calc_seq_core.sv
// Directed bench for calc_seq_core (WIDTH=8, SYNC_STAGES=2): a vector table
// of single ops plus hand-written abort, conflict and reset sequences.
module tb_calc_seq_core;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   a = 8'd0;
  logic [W-1:0]   b = 8'd0;
  logic [4:0]     btns = 5'b00000;  // {BTNC, DIV, MUL, SUB, ADD}
  logic [2*W-1:0] out;
  logic           busy, done, err_div0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  calc_seq_core #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .A         (a),
    .B         (b),
    .BTN_ADD   (btns[0]),
    .BTN_SUB   (btns[1]),
    .BTN_MUL   (btns[2]),
    .BTN_DIV   (btns[3]),
    .BTNC      (btns[4]),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .err_div0  (err_div0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Press buttons in mask for hold cycles, optionally inject inj_mask first
  // sampled at edge inj_k, and observe 14 edges from the first sampling edge.
  task automatic run_window(input logic [4:0] mask, input int hold,
                            input logic [4:0] inj_mask, input int inj_k,
                            output int lat, output int busy_cnt,
                            output int done_cnt, output logic [15:0] dout);
    lat = -1; busy_cnt = 0; done_cnt = 0; dout = 16'h0000;
    @(negedge clk);
    btns = btns | mask;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k;
          dout = out;
        end
      end
      if (busy) busy_cnt++;
      if (k == hold - 1) btns = btns & ~mask;
      if (k == 4) begin
        a = ~a;
        b = ~b;
      end
      if (k == inj_k - 1) btns = btns | inj_mask;
      if (k == inj_k + 1) btns = btns & ~inj_mask;
    end
  endtask

  typedef struct {
    logic [4:0]  mask;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] exp_out;
    logic        exp_err;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int lat, bc, dc;
    logic [15:0] dout;

    vecs[0]  = '{5'b00001, 8'd200, 8'd100, 16'h012C, 1'b0, 2, 0};
    vecs[1]  = '{5'b00010, 8'd5,   8'd9,   16'hFFFC, 1'b0, 2, 0};
    vecs[2]  = '{5'b00100, 8'd255, 8'd255, 16'hFE01, 1'b0, 11, 8};
    vecs[3]  = '{5'b01000, 8'd200, 8'd7,   16'h041C, 1'b0, 11, 8};
    vecs[4]  = '{5'b01000, 8'd13,  8'd0,   16'h0DFF, 1'b1, 3, 0};
    vecs[5]  = '{5'b00001, 8'd1,   8'd1,   16'h0002, 1'b0, 2, 0};
    vecs[6]  = '{5'b00001, 8'd255, 8'd255, 16'h01FE, 1'b0, 2, 0};
    vecs[7]  = '{5'b00010, 8'd0,   8'd255, 16'hFF01, 1'b0, 2, 0};
    vecs[8]  = '{5'b00100, 8'd16,  8'd16,  16'h0100, 1'b0, 11, 8};
    vecs[9]  = '{5'b00100, 8'd0,   8'd37,  16'h0000, 1'b0, 11, 8};
    vecs[10] = '{5'b01000, 8'd255, 8'd1,   16'h00FF, 1'b0, 11, 8};
    vecs[11] = '{5'b01000, 8'd7,   8'd200, 16'h0700, 1'b0, 11, 8};
    vecs[12] = '{5'b01000, 8'd255, 8'd255, 16'h0001, 1'b0, 11, 8};
    vecs[13] = '{5'b00100, 8'd13,  8'd11,  16'h008F, 1'b0, 11, 8};

    #12;
    check("reset_out", 32'(out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(err_div0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      a = vecs[i].va;
      b = vecs[i].vb;
      run_window(vecs[i].mask, 4, 5'b00000, -10, lat, bc, dc, dout);
      check($sformatf("v%0d_out", i), 32'(dout), 32'(vecs[i].exp_out));
      check($sformatf("v%0d_err", i), 32'(err_div0), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      check($sformatf("v%0d_done_pulses", i), dc, 1);
    end

    // ADD pressed while MUL runs is dropped
    a = 8'd255; b = 8'd255;
    run_window(5'b00100, 4, 5'b00001, 5, lat, bc, dc, dout);
    check("mul_add_drop_out", 32'(dout), 32'hFE01);
    check("mul_add_drop_lat", lat, 11);
    check("mul_add_drop_dones", dc, 1);

    // BTNC aborts a MUL and clears a sticky divide-by-zero flag
    a = 8'd13; b = 8'd0;
    run_window(5'b01000, 4, 5'b00000, -10, lat, bc, dc, dout);
    check("pre_abort_err", 32'(err_div0), 32'h1);
    a = 8'd3; b = 8'd3;
    run_window(5'b00100, 4, 5'b10000, 5, lat, bc, dc, dout);
    check("abort_dones", dc, 0);
    check("abort_busy_cycles", bc, 4);
    check("abort_out", 32'(out), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_err", 32'(err_div0), 32'h0);

    // Simultaneous ADD and SUB are ignored
    a = 8'd1; b = 8'd2;
    run_window(5'b00001, 4, 5'b00000, -10, lat, bc, dc, dout);
    check("pre_conflict_out", 32'(dout), 32'h3);
    a = 8'd50; b = 8'd60;
    run_window(5'b00011, 4, 5'b00000, -10, lat, bc, dc, dout);
    check("conflict_dones", dc, 0);
    check("conflict_out", 32'(out), 32'h3);

    // Asynchronous reset in the middle of a DIV
    a = 8'd200; b = 8'd7;
    @(negedge clk);
    btns = 5'b01000;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) btns = 5'b00000;
    end
    check("mid_div_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    check("async_rst_err", 32'(err_div0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Recovery after reset
    a = 8'd200; b = 8'd7;
    run_window(5'b01000, 4, 5'b00000, -10, lat, bc, dc, dout);
    check("post_rst_div_out", 32'(dout), 32'h041C);
    check("post_rst_div_lat", lat, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
